restoring_divider: RTL and testbench
====================================

RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, width of the dividend, divisor, quotient and remainder.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a new division; sampled on the clk rising edge.
REQ-005 SHALL have port: A  input  WIDTH  dividend (unsigned).
REQ-006 SHALL have port: B  input  WIDTH  divisor (unsigned).
REQ-007 SHALL have port: Q  output  WIDTH  quotient (registered).
REQ-008 SHALL have port: R  output  WIDTH  remainder (registered).
REQ-009 SHALL have port: busy  output  1  high while an iteration is in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse; Q/R valid.
REQ-011 SHALL have port: dbz  output  1  divide-by-zero flag, valid with done.

Function
REQ-012 SHALL use a three-state FSM: IDLE, CALC, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; on acceptance it SHALL latch A and B, clear the partial remainder, load the iteration counter with WIDTH and enter CALC.
REQ-014 SHALL ignore start while in CALC; latched operands and progress SHALL be unaffected.
REQ-015 SHALL perform one restoring step per CALC cycle: shift {rem, dividend} left 1; trial = rem - divisor on WIDTH+1 bits; if trial is non-negative, rem = trial and quotient bit = 1, else quotient bit = 0.
REQ-016 SHALL stay in CALC for exactly WIDTH cycles, then enter DONE.
REQ-017 SHALL load Q and R on entry to DONE and hold them until the next entry to DONE or reset.
REQ-018 SHALL assert done only in DONE (exactly one cycle) and busy only in CALC; they SHALL never be high together.
REQ-019 SHALL give a latency from the start cycle to the done cycle of WIDTH+1 clocks for a non-zero divisor.
REQ-020 SHALL, when in DONE with start low, return to IDLE; with start high, go directly to CALC (back-to-back operation).
REQ-021 SHALL produce Q = floor(A/B) and R = A mod B for all B != 0, including A < B (Q=0, R=A) and A = 0.
REQ-022 SHALL, for B = 0 without the zero-check feature, yield the natural algorithm result: Q = all ones, R = A, dbz = 0.

Reset
REQ-023 SHALL, on rst high, immediately force state=IDLE, Q=0, R=0, busy=0, done=0, dbz=0 and clear internal registers, regardless of edge or state.
REQ-024 SHALL abandon any in-progress division on reset with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-025 SHALL, with macro RESTORING_DIVIDER_DBZ_EN defined, detect B = 0 at start acceptance and go directly to DONE on the next edge (latency 1 clock), with Q = all ones, R = A and dbz = 1 for that done cycle.
REQ-026 SHALL, with RESTORING_DIVIDER_DBZ_EN defined, clear dbz whenever done is low and on every non-zero-divisor result.
REQ-027 SHALL, without RESTORING_DIVIDER_DBZ_EN, tie dbz to 0 and treat B = 0 as an ordinary WIDTH-cycle division per REQ-022.

Verification (WIDTH=8)
REQ-028 SHALL cover: start with A=13, B=4 -> done exactly 9 clocks later, Q=3, R=1, busy high for 8 cycles.
REQ-029 SHALL cover: A=255, B=1 then back-to-back start in the done cycle with A=7, B=200 -> Q=255, R=0; then Q=0, R=7 nine clocks later.
REQ-030 SHALL cover: A=100, B=0 -> with macro, done after 1 clock with dbz=1, Q=255, R=100; without macro, done after 9 clocks with dbz=0, Q=255, R=100.
REQ-031 SHALL cover: start A=50, B=7 then start A=9, B=3 in CALC cycle 3 -> second request ignored; Q=7, R=1 at cycle 9.
REQ-032 SHALL cover: rst pulsed between clock edges in CALC cycle 4 -> all outputs 0 immediately, no done; a following start with A=200, B=9 -> Q=22, R=2.

Source files
------------

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, WIDTH+1 clocks from start to done.
// Optional macro RESTORING_DIVIDER_DBZ_EN: a zero divisor short-circuits to DONE in one clock and raises dbz.
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [1:0]       state_dbg
);

  // Handshake: start is a request sampled on the rising edge and is accepted only
  // when busy is low (IDLE or DONE); done is a one-cycle strobe during which
  // Q, R and dbz describe the most recently accepted request.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;
  logic             dbz_q;

  logic             accept;
  logic             zero_div;
  logic             last_step;
  logic [WIDTH:0]   rem_sh;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] dvd_step;

`ifdef RESTORING_DIVIDER_DBZ_EN
  assign zero_div = (B == '0);
`else
  assign zero_div = 1'b0;
`endif

  assign accept    = start && (state != CALC);
  assign last_step = (cnt == CW'(1));

  // The shifted partial remainder is always below 2*divisor, so a WIDTH-bit
  // subtraction is exact whenever the trial is non-negative.
  always_comb begin
    rem_sh   = {rem, dvd[WIDTH-1]};
    q_bit    = (rem_sh >= {1'b0, dsr});
    rem_step = q_bit ? (rem_sh[WIDTH-1:0] - dsr) : rem_sh[WIDTH-1:0];
    dvd_step = {dvd[WIDTH-2:0], q_bit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = zero_div ? DONE : CALC;
      end
      CALC: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        if (start) state_nxt = zero_div ? DONE : CALC;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd   <= '0;
      dsr   <= '0;
      rem   <= '0;
      cnt   <= '0;
      Q     <= '0;
      R     <= '0;
      dbz_q <= 1'b0;
    end else if (accept) begin
      dvd <= A;
      dsr <= B;
      rem <= '0;
      cnt <= CW'(WIDTH);
      if (zero_div) begin
        Q     <= '1;
        R     <= A;
        dbz_q <= 1'b1;
      end
    end else if (state == CALC) begin
      dvd <= dvd_step;
      rem <= rem_step;
      cnt <= cnt - CW'(1);
      if (last_step) begin
        Q     <= dvd_step;
        R     <= rem_step;
        dbz_q <= 1'b0;
      end
    end
  end

  assign busy      = (state == CALC);
  assign done      = (state == DONE);
  // dbz_q only ever rises on the zero-divisor path; masking keeps it off outside done.
  assign dbz       = dbz_q & done;
  assign state_dbg = state;

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider (WIDTH=8): directed vectors with hand-computed results,
// expected {dbz,Q,R}, done cycle and busy-run length queued at issue time and checked on done.
module tb_restoring_divider;

  localparam int W = 8;
`ifdef RESTORING_DIVIDER_DBZ_EN
  localparam bit DBZ_EN = 1'b1;
`else
  localparam bit DBZ_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         done;
  logic         dbz;
  logic [1:0]   state_dbg;

  logic [2*W:0] exp_q[$];
  int           cyc_q[$];
  int           busy_q[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int busy_run = 0;

  restoring_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (a),
    .B         (b),
    .Q         (q),
    .R         (r),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks: called at a negedge, return at the following negedge
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic ed, input int lat, input int blen);
    exp_q.push_back({ed, eq, er});
    cyc_q.push_back(cyc + lat);
    busy_q.push_back(blen);
    start = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic poke(input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no done within 30 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_pending", exp_q.size(), 0);
  endtask

  // scoreboard monitor
  initial begin
    logic [2*W:0] e;
    int ec;
    int eb;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_run = 0;
      end else begin
        if (busy && done) begin
          checks++;
          errors++;
          $display("FAIL busy_done_overlap: busy=1 done=1 (cycle %0d)", cyc);
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: Q=%0d R=%0d dbz=%0d expected no done (cycle %0d)", q, r, dbz, cyc);
          end else begin
            e  = exp_q.pop_front();
            ec = cyc_q.pop_front();
            eb = busy_q.pop_front();
            check("result_dbz_q_r", {15'd0, dbz, q, r}, {15'd0, e});
            check("done_cycle", cyc, ec);
            check("busy_cycles", busy_run, eb);
          end
          busy_run = 0;
        end else if (busy) begin
          busy_run++;
        end
      end
    end
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", dbz, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
    @(negedge clk);

    // basic division
    issue(8'd13, 8'd4, 8'd3, 8'd1, 1'b0, 9, 8);
    drain();

    // back-to-back: second start in the done cycle of the first
    issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9, 8);
    wait_done();
    issue(8'd7, 8'd200, 8'd0, 8'd7, 1'b0, 9, 8);
    drain();

    // divide by zero
    if (DBZ_EN) issue(8'd100, 8'd0, 8'd255, 8'd100, 1'b1, 1, 0);
    else        issue(8'd100, 8'd0, 8'd255, 8'd100, 1'b0, 9, 8);
    drain();

    // zero dividend and equal operands
    issue(8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 9, 8);
    drain();
    issue(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9, 8);
    drain();

    // start during CALC cycle 3 is ignored
    issue(8'd50, 8'd7, 8'd7, 8'd1, 1'b0, 9, 8);
    @(negedge clk);
    @(negedge clk);
    poke(8'd9, 8'd3);
    drain();

    // asynchronous reset mid-calculation
    poke(8'd13, 8'd4);
    repeat (3) @(negedge clk);
    check("calc4_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_q", q, 0);
    check("arst_r", r, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_dbz", dbz, 0);
    check("arst_state", state_dbg, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_q", q, 0);
    issue(8'd200, 8'd9, 8'd22, 8'd2, 1'b0, 9, 8);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
